// File: rtl/alu64_pipe_stage_if.sv
// Upstream/downstream handshake bundle for the 64-bit ALU execute stage.
// master = producer/consumer side (decode + writeback), slave = the ALU stage.
interface alu64_pipe_stage_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_carry;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf
    );
endinterface

// File: rtl/alu64_pipe_stage.sv
// Two-stage 64-bit ALU execute stage (operand regs -> result/flag regs), valid/ready both sides.
// Macro ALU_SHIFT_EN: opcode 111 becomes logical shift left; otherwise it passes A through.
module alu_and_lane #(
    parameter int VEC_W = 16
) (
    input  logic [VEC_W-1:0] a,
    input  logic [VEC_W-1:0] b,
    output logic [VEC_W-1:0] y
);
    assign y = a & b;
endmodule

module alu_and64 #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 16
) (
    input  logic [NUM_LANES-1:0][VEC_W-1:0] a,
    input  logic [NUM_LANES-1:0][VEC_W-1:0] b,
    output logic [NUM_LANES-1:0][VEC_W-1:0] y
);
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        alu_and_lane #(.VEC_W(VEC_W)) u_lane (.a(a[i]), .b(b[i]), .y(y[i]));
    end
endmodule

module alu64_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu64_pipe_stage_if.slave   bus
);
    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;
    localparam logic [OP_W-1:0] OP_SLT = 3'b110;

    logic              s1_valid, s2_valid;
    logic              s1_adv, s2_adv;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic [OP_W-1:0]   s1_op;
    logic [DATA_W-1:0] and_y;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] res;
    logic              carry, ovf;

    // Stall only when S2 holds an unaccepted result; bubbles are always filled.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a  <= bus.in_a;
                s1_b  <= bus.in_b;
                s1_op <= bus.in_op;
            end
        end
    end

    alu_and64 #(.NUM_LANES(4), .VEC_W(DATA_W/4)) u_and (.a(s1_a), .b(s1_b), .y(and_y));

    // SUB is A + ~B + 1, so bit DATA_W is the not-borrow carry.
    assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff = {1'b0, s1_a} + {1'b0, ~s1_b} + (DATA_W+1)'(1);

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (s1_op)
            OP_AND: res = and_y;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_NOR: res = ~(s1_a | s1_b);
            OP_ADD: begin
                {carry, res} = sum;
                ovf = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (sum[DATA_W-1] != s1_a[DATA_W-1]);
            end
            OP_SUB: begin
                {carry, res} = diff;
                ovf = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (diff[DATA_W-1] != s1_a[DATA_W-1]);
            end
            OP_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: begin
`ifdef ALU_SHIFT_EN
                // Shift through a 65-bit window: bit DATA_W is the last bit shifted out.
                {carry, res} = {1'b0, s1_a} << s1_b[$clog2(DATA_W)-1:0];
`else
                res = s1_a;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            bus.out_result <= '0;
            bus.out_zero   <= 1'b0;
            bus.out_carry  <= 1'b0;
            bus.out_ovf    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_result <= res;
                bus.out_zero   <= (res == '0);
                bus.out_carry  <= carry;
                bus.out_ovf    <= ovf;
            end
        end
    end
endmodule

// File: doc/alu64_pipe_stage.md
Name: alu64_pipe_stage

Overview:
- Two-stage pipelined 64-bit ALU execute stage with valid/ready handshakes on both sides.
- Instantiates the team's 64-bit bitwise AND unit, alongside OR/XOR/NOR/ADD/SUB/SLT logic.
- Registers operands, computes, registers result plus flags.
- Sits between decode/register-read (upstream) and writeback (downstream).

Parameters:
- DATA_W, 64, operand/result width; only 64 supported (AND unit is fixed 64-bit).
- OP_W, 3, opcode width.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents operands/op
- in_ready  output  1  stage can accept this cycle
- in_a  input  64  operand A
- in_b  input  64  operand B
- in_op  input  3  opcode
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_result  output  64  registered result
- out_zero  output  1  result == 0
- out_carry  output  1  carry-out (ADD) / not-borrow (SUB); 0 for other ops
- out_ovf  output  1  signed overflow (ADD/SUB); 0 for other ops

Behaviour:
- Reset (async assert, sync-released use): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_zero=0, out_carry=0, out_ovf=0; in_ready=1 after reset.
- Opcodes: 000 AND (via AND unit), 001 OR, 010 XOR, 011 NOR, 100 ADD (65-bit sum, carry=bit64), 101 SUB (A+~B+1, carry=bit64), 110 SLT (signed A<B → 64'd1 else 0), 111 PASS_A (see optional feature).
- Overflow: ADD ovf = (A[63]==B[63]) && (R[63]!=A[63]); SUB ovf = (A[63]!=B[63]) && (R[63]!=A[63]).
- out_zero always = (out_result==0), registered with result.
- Stage 1 (S1): captures in_a/in_b/in_op when in_valid && in_ready.
- Stage 2 (S2): computes from S1 registers; captures result/flags when S1 valid and S2 advancing.
- Advance rules (no bubbles): s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational).
- Latency: 2 cycles from accepted input to out_valid when out_ready held high; throughput 1 op/cycle.
- Backpressure: out_ready=0 with both stages full → in_ready=0; all registers hold; out_* stable while out_valid && !out_ready.
- Simultaneous out handshake + new input on full pipeline: both stages shift in same cycle, no loss or duplication.
- in_valid=0 while advancing: the corresponding valid bit clears; data registers may hold stale values.
- Reset mid-operation: all in-flight ops discarded immediately; no output handshake completes in the reset cycle.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: opcode 111 = logical shift left, A << B[5:0]; carry = last bit shifted out (0 when shamt=0); ovf=0.
- Undefined: opcode 111 = PASS_A (result=A, carry=0, ovf=0); no shifter logic synthesized.

Test Plan:
- AND: A=64'hFFFF_0000_FFFF_0000, B=64'h0F0F_0F0F_0F0F_0F0F, op=000, out_ready=1 → 2 cycles later out_result=64'h0F0F_0000_0F0F_0000, zero=0.
- ADD overflow/carry: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 → result=64'h8000_0000_0000_0000, ovf=1, carry=0. A=64'hFFFF_FFFF_FFFF_FFFF, B=1 → result=0, zero=1, carry=1, ovf=0.
- SUB/SLT: A=5, B=5, SUB → result=0, zero=1, carry=1. A=64'hFFFF_FFFF_FFFF_FFFE (−2), B=3, SLT → result=1.
- Backpressure: stream 4 ops back-to-back; hold out_ready=0 from cycle 2 for 3 cycles → in_ready=0 once both stages full; out_result held stable; on release, 4 results emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 ops in flight → out_valid=0 and out_result=0 immediately; after release, first new op appears after exactly 2 cycles.
- Opcode 111, A=64'h1, B=64'd63: with ALU_SHIFT_EN → result=64'h8000_0000_0000_0000, carry=0; without it → result=64'h1.
